bka_pipe_adder: RTL and testbench
=================================

BKA_PIPE_ADDER -- requirements
Module: bka_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits; SHALL be a multiple of SEG and at least SEG.
REQ-002 Parameter SEG, default 8, segment width in bits; one segment is resolved per pipeline stage by a Brent-Kung prefix tree; SHALL be a power of two, 4..32.
REQ-003 Derived constant STAGES = WIDTH/SEG (default 4) SHALL set the pipeline depth.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand set offered this cycle.
REQ-007 in_ready  output  1  block accepts the operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; ignored when sub=1.
REQ-011 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-012 out_valid  output  1  result registered and valid.
REQ-013 out_ready  input  1  consumer takes the result this cycle.
REQ-014 q  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-018 Global advance signal adv = !out_valid || out_ready; in_ready SHALL equal adv; all stage registers SHALL load only when adv=1.
REQ-019 Stage k (0..STAGES-1) SHALL compute segment k: p/g per bit, Brent-Kung prefix over SEG bits, carry-in from the registered carry of stage k-1 (stage 0: sub ? 1 : cin).
REQ-020 Operand bits above segment k SHALL travel down the pipeline unmodified (b pre-inverted when sub=1); finished sum segments SHALL travel with them so q is aligned at the output.
REQ-021 Latency: a result accepted at edge N SHALL appear with out_valid=1 after edge N+STAGES-1 (available during cycle N+STAGES-1 onwards), given adv=1 throughout.
REQ-022 Throughput: one operation per cycle while out_ready=1; no bubbles inserted.
REQ-023 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while adv=1) SHALL propagate as invalid slots and never produce out_valid.
REQ-024 While adv=0 every stage register, q, cout, ovf and out_valid SHALL hold; no operation lost, duplicated or reordered.
REQ-025 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 q, cout, ovf SHALL be don't-care-free: they hold last valid result when out_valid=0 after a drain, and 0 after reset.

Reset
REQ-027 When rst_n=0 at a rising edge, all stage valid bits, out_valid, q, cout, ovf and internal carries SHALL clear to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 in the first cycle after reset release.
REQ-029 Inputs presented during a reset cycle SHALL NOT be accepted.

Configuration
REQ-030 Macro BKA_PIPE_FLAGS_EN: when defined, cout and ovf are computed per REQ-015/REQ-025 and pipelined with q.
REQ-031 When BKA_PIPE_FLAGS_EN is undefined, cout and ovf ports SHALL remain present and be driven constant 0; q, latency and handshake unchanged.

Verification (WIDTH=32, SEG=8, macro defined unless stated)
REQ-032 Reset: hold rst_n=0 2 cycles, release -> out_valid=0, q=0, cout=0, ovf=0, in_ready=1.
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 accepted at edge N -> out_valid=1 after edge N+3, q=0x00000000, cout=1, ovf=0; a=0x7FFFFFFF, b=1 -> q=0x80000000, cout=0, ovf=1.
REQ-034 sub=1, a=0x00000005, b=0x00000007 -> q=0xFFFFFFFE, cout=0, ovf=0; sub=1, a=0x80000000, b=1 -> q=0x7FFFFFFF, cout=1, ovf=1.
REQ-035 Backpressure: 6 back-to-back ops (a=i, b=0x100*i), out_ready=0 for 3 cycles once first result valid -> in_ready=0 during stall, outputs held, all 6 results delivered in order, none dropped or repeated.
REQ-036 Reset mid-flight: 3 ops in pipe, rst_n=0 one cycle -> no out_valid for those ops; new op accepted next cycle emerges after 4-cycle latency.
REQ-037 Macro undefined: rerun REQ-033/REQ-034 -> identical q and timing, cout=0 and ovf=0 always.

Source files
------------

// File: rtl/bka_pipe_adder_if.sv
// Handshake and data bundle for bka_pipe_adder: operand side (in_valid/in_ready, a, b, cin, sub)
// and result side (out_valid/out_ready, q, cout, ovf).
// master = the agent that supplies operands and consumes results; slave = the adder itself.
interface bka_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, q, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, q, cout, ovf
  );
endinterface

// File: rtl/bka_pipe_adder.sv
// Pipelined adder/subtractor: each stage resolves one SEG-bit segment with a Brent-Kung prefix tree.
// Latency WIDTH/SEG cycles (operation accepted at edge N is valid after edge N+STAGES-1), one op/cycle.
// Backpressure: global advance = !out_valid || out_ready; in_ready = advance; all stages freeze when 0.
// Ports: clk, rst_n (synchronous, active-low); io (bka_pipe_adder_if.slave) carries both handshakes,
// operands a/b/cin/sub and results q/cout/ovf.
// Optional macro BKA_PIPE_FLAGS_EN: when defined, cout/ovf are computed and pipelined with q;
// otherwise both are tied to 0.
module bka_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic clk,
  input  logic rst_n,
  bka_pipe_adder_if.slave io
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LOG    = $clog2(SEG);

  logic adv;
  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;

  // Brent-Kung segment adder: returns {carry out, sum}.
  // Up-sweep builds power-of-two group terms; down-sweep fills in the remaining prefixes.
  function automatic logic [SEG:0] bk_seg(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] gg;
    logic [SEG-1:0] pp;
    logic [SEG:0]   c;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int l = 0; l < LOG; l++) begin
      for (int i = (2 << l) - 1; i < SEG; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < SEG; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = gg[i] | (pp[i] & ci);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG;        // lowest bit resolved by this stage
    localparam int RW = WIDTH - LO;     // operand bits still unresolved on entry
    localparam int SW = LO + SEG;       // finished sum bits on exit

    logic [RW-1:0] a_in;
    logic [RW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [SEG:0]  r;
    logic [SW-1:0] s_nxt;
    logic [SW-1:0] s_q;
    logic          v_q;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1, so the injected carry is forced high.
      assign a_in  = io.a;
      assign b_in  = io.sub ? ~io.b : io.b;
      assign c_in  = io.sub | io.cin;
      assign v_in  = io.in_valid;
      assign s_nxt = r[SEG-1:0];
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_fwd.a_q;
      assign b_in  = g_stg[k-1].g_fwd.b_q;
      assign c_in  = g_stg[k-1].g_fwd.c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_nxt = {r[SEG-1:0], g_stg[k-1].s_q};
    end

    assign r = bk_seg(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

    // Data only loads for valid slots so q keeps the last real result after a drain.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          s_q <= s_nxt;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Unresolved upper operand bits and the segment carry ride along to the next stage.
      logic [RW-SEG-1:0] a_q;
      logic [RW-SEG-1:0] b_q;
      logic              c_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv && v_in) begin
          a_q <= a_in[RW-1:SEG];
          b_q <= b_in[RW-1:SEG];
          c_q <= r[SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign io.out_valid = v_q;
      assign io.q         = s_q;
`ifdef BKA_PIPE_FLAGS_EN
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit; overflow is it XOR carry out.
      logic cout_q;
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv && v_in) begin
          cout_q <= r[SEG];
          ovf_q  <= a_in[SEG-1] ^ b_in[SEG-1] ^ r[SEG-1] ^ r[SEG];
        end
      end
      assign io.cout = cout_q;
      assign io.ovf  = ovf_q;
`else
      assign io.cout = 1'b0;
      assign io.ovf  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_bka_pipe_adder.sv
// Directed bench for bka_pipe_adder (WIDTH=32, SEG=8): reset, add/sub corner vectors with
// latency and hold checks, backpressure ordering, and reset while operations are in flight.
module tb_bka_pipe_adder;

`ifdef BKA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  bka_pipe_adder_if #(.WIDTH(32)) io ();

  bka_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io.slave)
  );

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    io.in_valid = 1'b1; io.a = 32'h0000_DEAD; io.b = 32'h1; io.cin = 1'b0; io.sub = 1'b0;
    io.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    io.in_valid = 1'b0;
    #1;
    vecs++;
    if (io.out_valid !== 1'b0 || io.q !== 32'h0 || io.cout !== 1'b0 || io.ovf !== 1'b0 ||
        io.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_state: out_valid=%b q=%h cout=%b ovf=%b in_ready=%b want 0 00000000 0 0 1",
               io.out_valid, io.q, io.cout, io.ovf, io.in_ready);
    end
    // Operand offered during reset must never surface.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_no_accept cyc%0d: out_valid=%b want 0", c, io.out_valid);
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] ta [5];
    logic [31:0] tb_ [5];
    logic        tc [5];
    logic [31:0] eq [5];
    logic        ec [5];
    logic        eo [5];
    logic        want_c, want_o;
    ta  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_00FF, 32'h1234_5678, 32'h8000_0000};
    tb_ = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0100, 32'h0FED_CBA9, 32'h8000_0000};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eq  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0200, 32'h2222_2221, 32'h0000_0000};
    ec  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    eo  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      want_c = ec[i] & FLAGS;
      want_o = eo[i] & FLAGS;
      @(negedge clk);
      io.a = ta[i]; io.b = tb_[i]; io.cin = tc[i]; io.sub = 1'b0;
      io.in_valid = 1'b1; io.out_ready = 1'b1;
      #1;
      vecs++;
      if (io.in_ready !== 1'b1) begin
        errs++;
        $display("FAIL add%0d_in_ready: got %b want 1", i, io.in_ready);
      end
      @(posedge clk);
      #1 io.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vecs++;
        if (io.out_valid !== 1'b0) begin
          errs++;
          $display("FAIL add%0d_early cyc%0d: out_valid=%b want 0", i, c, io.out_valid);
        end
      end
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b1 || io.q !== eq[i] || io.cout !== want_c || io.ovf !== want_o) begin
        errs++;
        $display("FAIL add%0d_result: v=%b q=%h c=%b o=%b want 1 %h %b %b",
                 i, io.out_valid, io.q, io.cout, io.ovf, eq[i], want_c, want_o);
      end
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b0 || io.q !== eq[i] || io.cout !== want_c || io.ovf !== want_o) begin
        errs++;
        $display("FAIL add%0d_hold: v=%b q=%h c=%b o=%b want 0 %h %b %b",
                 i, io.out_valid, io.q, io.cout, io.ovf, eq[i], want_c, want_o);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [4];
    logic [31:0] tb_ [4];
    logic        tc [4];
    logic [31:0] eq [4];
    logic        ec [4];
    logic        eo [4];
    logic        want_c, want_o;
    ta  = '{32'h0000_0005, 32'h8000_0000, 32'h0000_0010, 32'h0000_0000};
    tb_ = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b1};
    eq  = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_000D, 32'h0000_0000};
    ec  = '{1'b0, 1'b1, 1'b1, 1'b1};
    eo  = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      want_c = ec[i] & FLAGS;
      want_o = eo[i] & FLAGS;
      @(negedge clk);
      io.a = ta[i]; io.b = tb_[i]; io.cin = tc[i]; io.sub = 1'b1;
      io.in_valid = 1'b1; io.out_ready = 1'b1;
      @(posedge clk);
      #1 io.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vecs++;
        if (io.out_valid !== 1'b0) begin
          errs++;
          $display("FAIL sub%0d_early cyc%0d: out_valid=%b want 0", i, c, io.out_valid);
        end
      end
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b1 || io.q !== eq[i] || io.cout !== want_c || io.ovf !== want_o) begin
        errs++;
        $display("FAIL sub%0d_result: v=%b q=%h c=%b o=%b want 1 %h %b %b",
                 i, io.out_valid, io.q, io.cout, io.ovf, eq[i], want_c, want_o);
      end
    end
  endtask

  task automatic test_backpressure();
    int tx = 0;
    int rx = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;
    logic [31:0] want;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      if (!stall_done && io.out_valid === 1'b1) begin
        stall_left = 3;
        stall_done = 1'b1;
      end
      io.out_ready = (stall_left == 0);
      io.in_valid  = (tx < 6);
      io.a   = 32'(tx + 1);
      io.b   = 32'h100 * 32'(tx + 1);
      io.cin = 1'b0;
      io.sub = 1'b0;
      #1;
      want = 32'h101 * 32'(rx + 1);
      vecs++;
      if (stall_left > 0) begin
        if (io.in_ready !== 1'b0 || io.out_valid !== 1'b1 || io.q !== want) begin
          errs++;
          $display("FAIL bp_stall cyc%0d: in_ready=%b v=%b q=%h want 0 1 %h",
                   cyc, io.in_ready, io.out_valid, io.q, want);
        end
      end else if (io.in_ready !== 1'b1) begin
        errs++;
        $display("FAIL bp_in_ready cyc%0d: got %b want 1", cyc, io.in_ready);
      end
      if (io.in_valid && io.in_ready) tx++;
      if (io.out_valid === 1'b1 && io.out_ready) begin
        vecs++;
        if (io.q !== want) begin
          errs++;
          $display("FAIL bp_order res%0d: q=%h want %h", rx, io.q, want);
        end
        rx++;
      end
      if (stall_left > 0) stall_left--;
    end
    io.in_valid = 1'b0;
    vecs++;
    if (rx != 6 || tx != 6 || !stall_done) begin
      errs++;
      $display("FAIL bp_count: sent=%0d received=%0d stalled=%0d want 6 6 1", tx, rx, stall_done);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL bp_extra cyc%0d: out_valid=%b q=%h want 0", c, io.out_valid, io.q);
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1; io.a = 32'(16 + i); io.b = 32'h0; io.cin = 1'b0; io.sub = 1'b0;
      io.out_ready = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    io.a = 32'h0000_1000;
    @(negedge clk);
    rst_n = 1'b1;
    io.a = 32'h11; io.b = 32'h22; io.in_valid = 1'b1;
    #1;
    vecs++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || io.q !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid_release: in_ready=%b v=%b q=%h want 1 0 00000000",
               io.in_ready, io.out_valid, io.q);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if (io.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL rst_mid_flush cyc%0d: out_valid=%b q=%h want 0", c, io.out_valid, io.q);
      end
    end
    @(negedge clk);
    vecs++;
    if (io.out_valid !== 1'b1 || io.q !== 32'h33) begin
      errs++;
      $display("FAIL rst_mid_new: v=%b q=%h want 1 00000033", io.out_valid, io.q);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.sub = 1'b0; io.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
